// File: rtl/ad9837_pkg.sv
// ----------------------------------------------------------------------------
// ad9837_pkg
// Constants shared by the AD9837 serial register decoder: register address
// codes carried in word[15:14], control-register bit positions, field widths
// and the receive FSM state type.
// Optional build feature: AD9837_DEC_ERR_CNT_EN (see ad9837_reg_decoder).
// ----------------------------------------------------------------------------
package ad9837_pkg;

    // Field widths
    localparam int WORD_W   = 16;
    localparam int FREQ_W   = 28;
    localparam int PHASE_W  = 12;
    localparam int CTRL_W   = 14;
    // Each frequency write carries one 14-bit half of the 28-bit register
    localparam int FREQ_HALF_W = 14;

    // Register address codes in word[15:14]
    localparam logic [1:0] ADDR_CTRL  = 2'b00;
    localparam logic [1:0] ADDR_FREQ0 = 2'b01;
    localparam logic [1:0] ADDR_FREQ1 = 2'b10;
    localparam logic [1:0] ADDR_PHASE = 2'b11;

    // Control register bit positions
    localparam int B28_BIT = 13;   // 1: two consecutive writes form a 28-bit load
    localparam int HLB_BIT = 12;   // 1: single write targets the MSB half

    // Phase-register select bit inside a phase word
    localparam int PHASE_SEL_BIT = 13;

    // Serial receive FSM
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ad9837_spi_rx_shift.sv
// ----------------------------------------------------------------------------
// ad9837_spi_rx_shift
// Serial front end: synchronizes FSYNC/SCLK/SDATA into clk, detects SCLK
// falling edges and assembles 16-bit MSB-first words while FSYNC is low.
//
// Ports
//   clk        system clock (at least 4x SCLK)
//   rst        synchronous active-high reset
//   fsync      frame sync, active low (asynchronous)
//   sclk       serial clock, data sampled on its falling edge (asynchronous)
//   sdata      serial data, MSB first (asynchronous)
//   word_done  combinational: the current cycle completes a 16-bit word
//   word_data  combinational: the completed word (valid with word_done)
//   frame_err  combinational: FSYNC rose with a partial word (1..15 bits)
// ----------------------------------------------------------------------------
module ad9837_spi_rx_shift
    import ad9837_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fsync,
    input  logic              sclk,
    input  logic              sdata,
    output logic              word_done,
    output logic [WORD_W-1:0] word_data,
    output logic              frame_err
);

    // Bit order of the synchronizer bundle: [2]=fsync, [1]=sclk, [0]=sdata.
    // All three share the same depth so sdata stays aligned to its sclk edge.
    logic [2:0] raw;
    logic [2:0] synced;

    assign raw = {fsync, sclk, sdata};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
                end
            end

            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic fsync_s;
    logic sclk_s;
    logic sdata_s;
    logic sclk_fall;

    assign fsync_s = synced[2];
    assign sclk_s  = synced[1];
    assign sdata_s = synced[0];

    rx_state_t         state_reg, state_next;
    logic [3:0]        count_reg, count_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic              sclk_prev_reg;
    // The synchronizers reset to 0, which looks like FSYNC asserted. A frame
    // may only start once FSYNC has been seen high after reset, so a frame
    // already running when reset drops is ignored until FSYNC cycles.
    logic              armed_reg;

    assign sclk_fall = sclk_prev_reg & ~sclk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            sclk_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            sclk_prev_reg <= sclk_s;
            if (fsync_s) begin
                armed_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        word_done  = 1'b0;
        frame_err  = 1'b0;
        word_data  = {shift_reg[WORD_W-2:0], sdata_s};

        case (state_reg)
            ST_IDLE: begin
                // SCLK activity is ignored here
                if (armed_reg && !fsync_s) begin
                    state_next = ST_SHIFT;
                    count_next = '0;
                end
            end
            ST_SHIFT: begin
                if (fsync_s) begin
                    // FSYNC takes priority over a coincident SCLK edge
                    state_next = ST_IDLE;
                    count_next = '0;
                    if (count_reg != 4'd0) begin
                        frame_err = 1'b1;
                    end
                end else if (sclk_fall) begin
                    shift_next = {shift_reg[WORD_W-2:0], sdata_s};
                    // 4-bit counter wraps so back-to-back words need no FSYNC
                    count_next = count_reg + 4'd1;
                    if (count_reg == 4'd15) begin
                        word_done = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/ad9837_reg_decoder.sv
// ----------------------------------------------------------------------------
// ad9837_reg_decoder
// Receives AD9837-style 16-bit serial words and decodes them into the
// control, frequency (FREQ0/FREQ1) and phase (PHASE0/PHASE1) registers,
// including the B28 two-write 28-bit frequency load and HLB half selection.
//
// Optional feature: define AD9837_DEC_ERR_CNT_EN to add err_cnt_o, an 8-bit
// saturating count of frame_err_o pulses.
//
// Ports
//   clk_i         system clock (>= 4x SCLK)
//   rst_i         synchronous active-high reset
//   fsync_i       frame sync, active low
//   sclk_i        serial clock, falling-edge sampling
//   sdata_i       serial data, MSB first
//   word_o        last complete received word
//   word_valid_o  one-cycle pulse per complete word
//   frame_err_o   one-cycle pulse when FSYNC rises mid-word
//   ctrl_o        control register D13..D0
//   freq0_o/1_o   28-bit frequency registers
//   phase0_o/1_o  12-bit phase registers
//   err_cnt_o     (AD9837_DEC_ERR_CNT_EN only) saturating error count
// ----------------------------------------------------------------------------
module ad9837_reg_decoder
    import ad9837_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               fsync_i,
    input  logic               sclk_i,
    input  logic               sdata_i,
    output logic [WORD_W-1:0]  word_o,
    output logic               word_valid_o,
    output logic               frame_err_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [FREQ_W-1:0]  freq0_o,
    output logic [FREQ_W-1:0]  freq1_o,
    output logic [PHASE_W-1:0] phase0_o,
    output logic [PHASE_W-1:0] phase1_o
`ifdef AD9837_DEC_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt_o
`endif
);

    logic              word_done;
    logic [WORD_W-1:0] word_data;
    logic              frame_err;

    ad9837_spi_rx_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk       (clk_i),
        .rst       (rst_i),
        .fsync     (fsync_i),
        .sclk      (sclk_i),
        .sdata     (sdata_i),
        .word_done (word_done),
        .word_data (word_data),
        .frame_err (frame_err)
    );

    logic [1:0]             addr;
    logic [CTRL_W-1:0]      payload;
    logic                   freq_sel;   // 0: FREQ0, 1: FREQ1

    assign addr     = word_data[WORD_W-1 -: 2];
    assign payload  = word_data[CTRL_W-1:0];
    assign freq_sel = (addr == ADDR_FREQ1);

    logic [FREQ_W-1:0]      freq_reg [2];
    // B28 staging: first half-word of a 28-bit load and which register it targets
    logic                   pending_reg;
    logic                   pending_sel_reg;
    logic [FREQ_HALF_W-1:0] staged_reg;

    assign freq0_o = freq_reg[0];
    assign freq1_o = freq_reg[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_o          <= '0;
            word_valid_o    <= 1'b0;
            frame_err_o     <= 1'b0;
            ctrl_o          <= '0;
            freq_reg[0]     <= '0;
            freq_reg[1]     <= '0;
            phase0_o        <= '0;
            phase1_o        <= '0;
            pending_reg     <= 1'b0;
            pending_sel_reg <= 1'b0;
            staged_reg      <= '0;
        end else begin
            word_valid_o <= word_done;
            frame_err_o  <= frame_err;

            if (word_done) begin
                word_o <= word_data;
                case (addr)
                    ADDR_CTRL: begin
                        ctrl_o      <= payload;
                        pending_reg <= 1'b0;
                    end
                    ADDR_FREQ0, ADDR_FREQ1: begin
                        if (!ctrl_o[B28_BIT]) begin
                            if (ctrl_o[HLB_BIT]) begin
                                freq_reg[freq_sel][FREQ_W-1:FREQ_HALF_W] <= payload;
                            end else begin
                                freq_reg[freq_sel][FREQ_HALF_W-1:0] <= payload;
                            end
                        end else if (pending_reg && (pending_sel_reg == freq_sel)) begin
                            // Second write: whole register updates at once
                            freq_reg[freq_sel] <= {payload, staged_reg};
                            pending_reg        <= 1'b0;
                        end else begin
                            // First write, or a write to the other register
                            // which restarts the pair
                            pending_reg     <= 1'b1;
                            pending_sel_reg <= freq_sel;
                            staged_reg      <= payload;
                        end
                    end
                    ADDR_PHASE: begin
                        if (payload[PHASE_SEL_BIT]) begin
                            phase1_o <= payload[PHASE_W-1:0];
                        end else begin
                            phase0_o <= payload[PHASE_W-1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef AD9837_DEC_ERR_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (frame_err && (err_cnt_o != 8'hFF)) begin
            // Counts in step with the frame_err_o pulse
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ad9837_reg_decoder.sv
// ----------------------------------------------------------------------------
// tb_ad9837_reg_decoder
// Self-checking bench for ad9837_reg_decoder: directed frames followed by
// random frames, compared against an arithmetic register model.
// Define AD9837_DEC_ERR_CNT_EN to also check err_cnt_o.
// ----------------------------------------------------------------------------
module tb_ad9837_reg_decoder;

    logic        clk;
    logic        rst;
    logic        fsync;
    logic        sclk;
    logic        sdata;
    logic [15:0] word_o;
    logic        word_valid_o;
    logic        frame_err_o;
    logic [13:0] ctrl_o;
    logic [27:0] freq0_o;
    logic [27:0] freq1_o;
    logic [11:0] phase0_o;
    logic [11:0] phase1_o;
`ifdef AD9837_DEC_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    ad9837_reg_decoder #(
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fsync_i      (fsync),
        .sclk_i       (sclk),
        .sdata_i      (sdata),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .frame_err_o  (frame_err_o),
        .ctrl_o       (ctrl_o),
        .freq0_o      (freq0_o),
        .freq1_o      (freq1_o),
        .phase0_o     (phase0_o),
        .phase1_o     (phase1_o)
`ifdef AD9837_DEC_ERR_CNT_EN
        ,
        .err_cnt_o    (err_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed pulse counters
    int obs_valid = 0;
    int obs_errs  = 0;

    always @(negedge clk) begin
        if (word_valid_o) obs_valid++;
        if (frame_err_o)  obs_errs++;
    end

    // Reference model (plain integer arithmetic)
    int m_ctrl;
    int m_freq [2];
    int m_phase [2];
    int m_pend;
    int m_ptgt;
    int m_staged;
    int m_word;
    int m_valid;
    int m_errs;

    task automatic model_reset();
        m_ctrl = 0; m_freq[0] = 0; m_freq[1] = 0;
        m_phase[0] = 0; m_phase[1] = 0;
        m_pend = 0; m_ptgt = 0; m_staged = 0; m_word = 0;
    endtask

    task automatic model_word(input int w);
        int a;
        int d;
        int t;
        a = w / 16384;
        d = w % 16384;
        m_word = w;
        m_valid++;
        if (a == 0) begin
            m_ctrl = d;
            m_pend = 0;
        end else if (a == 3) begin
            if ((d / 8192) % 2 == 1) m_phase[1] = d % 4096;
            else                     m_phase[0] = d % 4096;
        end else begin
            t = a - 1;
            if ((m_ctrl / 8192) % 2 == 0) begin
                if ((m_ctrl / 4096) % 2 == 1)
                    m_freq[t] = (m_freq[t] % 16384) + d * 16384;
                else
                    m_freq[t] = m_freq[t] - (m_freq[t] % 16384) + d;
            end else if (m_pend == 1 && m_ptgt == t) begin
                m_freq[t] = d * 16384 + m_staged;
                m_pend = 0;
            end else begin
                m_pend = 1;
                m_ptgt = t;
                m_staged = d;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ctrl"},   32'(ctrl_o),   32'(m_ctrl));
        check({tag, ".freq0"},  32'(freq0_o),  32'(m_freq[0]));
        check({tag, ".freq1"},  32'(freq1_o),  32'(m_freq[1]));
        check({tag, ".phase0"}, 32'(phase0_o), 32'(m_phase[0]));
        check({tag, ".phase1"}, 32'(phase1_o), 32'(m_phase[1]));
        check({tag, ".word"},   32'(word_o),   32'(m_word));
        check({tag, ".nvalid"}, 32'(obs_valid), 32'(m_valid));
        check({tag, ".nerr"},   32'(obs_errs),  32'(m_errs));
`ifdef AD9837_DEC_ERR_CNT_EN
        check({tag, ".errcnt"}, 32'(err_cnt_o), 32'(m_errs > 255 ? 255 : m_errs));
`endif
        $display("txn %-10s ctrl=%04h f0=%07h f1=%07h p0=%03h p1=%03h word=%04h nv=%0d ne=%0d",
                 tag, ctrl_o, freq0_o, freq1_o, phase0_o, phase1_o, word_o, obs_valid, obs_errs);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        fsync = 1'b0;
        clocks(4);
    endtask

    task automatic shift_bits(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sclk  = 1'b1;
            sdata = data[i];
            clocks(4);
            sclk  = 1'b0;
            clocks(4);
        end
    endtask

    task automatic frame_end();
        sclk = 1'b1;
        clocks(4);
        fsync = 1'b1;
        clocks(8);
    endtask

    task automatic frame(input logic [31:0] data, input int nbits);
        frame_start();
        shift_bits(data, nbits);
        frame_end();
    endtask

    task automatic send_word(input int w, input string tag);
        frame(32'(w), 16);
        model_word(w);
        check_all(tag);
    endtask

    initial begin
        int w;
        int nb;
        rst = 1'b1; fsync = 1'b1; sclk = 1'b1; sdata = 1'b0;
        m_valid = 0; m_errs = 0;
        model_reset();
        clocks(5);
        check_all("reset");
        check("reset.wvalid", 32'(word_valid_o), 32'd0);
        check("reset.ferr",   32'(frame_err_o),  32'd0);
        rst = 1'b0;
        clocks(5);

        // B28 two-write load into FREQ0
        send_word(16'h2000, "b28_ctrl");
        send_word(16'h50C7, "b28_lsb");
        check("b28_lsb.f0_zero", 32'(freq0_o), 32'd0);
        send_word(16'h4000, "b28_msb");
        check("b28_msb.f0", 32'(freq0_o), 32'h00010C7);

        // HLB single MSB-half write into FREQ1
        send_word(16'h1000, "hlb_ctrl");
        send_word(16'h8ABC, "hlb_f1");
        check("hlb_f1.msb", 32'(freq1_o[27:14]), 32'h0ABC);
        check("hlb_f1.lsb", 32'(freq1_o[13:0]),  32'h0000);

        // Phase registers
        send_word(16'hC123, "phase0");
        send_word(16'hE456, "phase1");

        // Short frame: 9 bits then FSYNC high
        frame(32'h1A5, 9);
        m_errs++;
        check_all("short9");

        // 32 bits in one frame: control then first B28 write to FREQ0
        frame(32'h2000_4001, 32);
        model_word(16'h2000);
        model_word(16'h4001);
        check_all("two_words");
        // Write to FREQ1 restarts the pair, then completes FREQ1
        send_word(16'h8005, "b28_other");
        send_word(16'h8003, "b28_f1_msb");
        check("b28_f1_msb.f1", 32'(freq1_o), 32'h000C005);

        // Random frames
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                nb = $urandom_range(1, 15);
                frame(32'($urandom), nb);
                m_errs++;
                check_all("rnd_short");
            end else begin
                w = int'($urandom_range(0, 65535));
                send_word(w, "rnd_word");
            end
        end

        // Reset mid-frame after 8 bits
        frame_start();
        shift_bits(32'hA5, 8);
        rst = 1'b1;
        clocks(1);
        model_reset();
        check_all("rst_mid");
        rst = 1'b0;
        shift_bits(32'h5, 3);
        frame_end();
        check_all("rst_after");

        // Normal operation resumes
        send_word(16'h3ABC, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9837_reg_decoder.md
AD9837_REG_DECODER -- requirements
Module: ad9837_reg_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each serial input (min 2).
REQ-002 SHALL have port clk_i, input, 1: system clock; reset is synchronous and active-high; clk_i frequency >= 4x SCLK.
REQ-003 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-004 SHALL have port fsync_i, input, 1: frame sync, active low.
REQ-005 SHALL have port sclk_i, input, 1: serial clock; data is sampled on its falling edge.
REQ-006 SHALL have port sdata_i, input, 1: serial data, MSB first.
REQ-007 SHALL have port word_o, output, 16: last complete received word.
REQ-008 SHALL have port word_valid_o, output, 1: one-cycle pulse per complete word.
REQ-009 SHALL have port frame_err_o, output, 1: one-cycle pulse on a short frame.
REQ-010 SHALL have port ctrl_o, output, 14: control register bits D13..D0.
REQ-011 SHALL have ports freq0_o and freq1_o, output, 28 each: frequency registers.
REQ-012 SHALL have ports phase0_o and phase1_o, output, 12 each: phase registers.

Function
REQ-013 SHALL pass fsync_i, sclk_i and sdata_i through SYNC_STAGES flops, then detect SCLK falling edges from the synchronized sclk (previous=1, current=0).
REQ-014 SHALL use an FSM with states IDLE (fsync high) and SHIFT (fsync low): IDLE->SHIFT on synchronized fsync low with bit count 0; SHIFT->IDLE on synchronized fsync high.
REQ-015 SHALL, in SHIFT on each falling edge, shift synchronized sdata into a 16-bit register LSB-side and increment a 4-bit bit counter.
REQ-016 SHALL, on the 16th edge, load word_o, pulse word_valid_o the next cycle and apply the decode in that same cycle; the counter wraps to 0, so edge 17 onward starts a new word without fsync rising.
REQ-017 SHALL, when fsync rises with bit count 1..15, pulse frame_err_o for one cycle, discard the partial word and leave all registers unchanged; a count of 0 gives no error.
REQ-018 SHALL ignore SCLK edges in IDLE.
REQ-019 SHALL decode word[15:14]: 00 -> ctrl_o <= word[13:0]; 01 -> FREQ0; 10 -> FREQ1; 11 with word[13]=0 -> phase0_o <= word[11:0]; 11 with word[13]=1 -> phase1_o <= word[11:0].
REQ-020 SHALL, for a frequency write with B28 (ctrl_o[13]) = 0, write word[13:0] to bits 27:14 if HLB (ctrl_o[12]) = 1, else to bits 13:0; the other half is unchanged.
REQ-021 SHALL, for a frequency write with B28 = 1, stage the first write (14 LSBs plus target) with no output change; the second write to the same target updates all 28 bits atomically as {MSB, staged LSB}.
REQ-022 SHALL, with B28 = 1, treat a second write to the other frequency register as a new first write, discarding the old staged value.
REQ-023 SHALL clear the B28 pending flag on any control write; phase writes SHALL NOT affect it.

Reset
REQ-024 SHALL, on rst_i, zero all outputs, the shift register, counter, pending flag and synchronizers, and enter IDLE within the same edge, including mid-frame.
REQ-025 SHALL treat a frame in progress when reset deasserts as not started: no word and no frame_err until fsync goes high then low again.

Configuration
REQ-026 SHALL, with AD9837_DEC_ERR_CNT_EN defined, add output err_cnt_o (8 bits, reset 0), incremented on each frame_err_o pulse and saturating at 255.
REQ-027 SHALL, without AD9837_DEC_ERR_CNT_EN, have no err_cnt_o port and no counter logic.

Structure
REQ-028 SHALL place the register address codes (00/01/10/11), control bit indices (B28=13, HLB=12) and widths (16/28/12) in shared package ad9837_pkg.
REQ-029 SHALL use one sub-module, ad9837_spi_rx_shift (synchronizer, edge detect, FSM, shifter); decode and registers stay in the top.

Verification
REQ-030 SHALL cover: words 0x2000, 0x50C7, 0x4000 -> freq0_o = 0x00010C7 after the third word only; freq0_o stays 0 after the second.
REQ-031 SHALL cover: words 0x1000, 0x8ABC -> freq1_o[27:14] = 0x0ABC and freq1_o[13:0] unchanged (0).
REQ-032 SHALL cover: words 0xC123, 0xE456 -> phase0_o = 0x123, phase1_o = 0x456, two word_valid_o pulses.
REQ-033 SHALL cover: fsync rises after 9 bits -> one frame_err_o pulse, no word_valid_o, registers unchanged, err_cnt_o = 1 with the macro defined.
REQ-034 SHALL cover: 32 bits in one fsync-low frame (0x2000, 0x4001) -> two word_valid_o pulses and the decode per REQ-021.
REQ-035 SHALL cover: rst_i asserted after 8 bits -> all outputs 0 next cycle; no frame_err_o when fsync then rises.
